// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-granular arbiter sharing one byte-wide UART transmitter
module uart_tx_scheduler #(
    parameter int N_REQ = 4,
    parameter int GAP_CYCLES = 16,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [8*N_REQ-1:0]       req_data_i,
    input  logic [N_REQ-1:0]         req_last_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     tx_start_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_busy_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     abort_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TW = HOLD_TIMEOUT > 0 ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GAP = 3'd5;
    localparam logic [2:0] S_AFTER = GAP_CYCLES > 0 ? S_GAP : S_IDLE;
    logic [2:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          last_flag;
    logic          accepted;
    logic [GW-1:0] gcnt;
    logic [TW-1:0] tcnt;
    logic          hs;
    logic          valid_g;
    logic          timeout;
    logic          gap_done;
    assign valid_g = req_valid_i[grant_id_o];
    assign req_ready_o = (state == S_SEND) ? (grant_o & req_valid_i & {N_REQ{~tx_busy_i}}) : '0;
    assign hs = |req_ready_o;
    assign tx_start_o = state == S_START;
    // only bytes after the first of a packet can time out
    assign timeout = (HOLD_TIMEOUT > 0) && state == S_SEND && accepted && !valid_g && (int'(tcnt) + 1 >= HOLD_TIMEOUT);
    assign gap_done = int'(gcnt) + 1 >= GAP_CYCLES;
    // descending scan so the candidate nearest rr_ptr+1 wins
    always_comb begin
        win = rr_ptr;
        cand = rr_ptr;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IW'((int'(rr_ptr) + i) % N_REQ);
            win = req_valid_i[cand] ? cand : win;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rr_ptr <= IW'(N_REQ - 1);
            grant_o <= '0;
            grant_id_o <= '0;
            tx_data_o <= '0;
            last_flag <= 1'b0;
            accepted <= 1'b0;
            gcnt <= '0;
            tcnt <= '0;
            abort_o <= 1'b0;
        end else begin
            abort_o <= timeout;
            case (state)
                S_IDLE: if (|req_valid_i) begin
                    grant_o <= N_REQ'(1) << win;
                    grant_id_o <= win;
                    accepted <= 1'b0;
                    tcnt <= '0;
                    state <= S_SEND;
                end
                S_SEND: if (hs) begin
                    tx_data_o <= req_data_i[{grant_id_o, 3'b000} +: 8];
                    last_flag <= req_last_i[grant_id_o];
                    accepted <= 1'b1;
                    tcnt <= '0;
                    state <= S_START;
                end else if (timeout) begin
                    rr_ptr <= grant_id_o;
                    grant_o <= '0;
                    tcnt <= '0;
                    state <= S_AFTER;
                end else if (accepted && !valid_g) begin
                    tcnt <= (&tcnt) ? tcnt : tcnt + 1'b1;
                end
                S_START: state <= S_WAIT_BUSY;
                S_WAIT_BUSY: if (tx_busy_i) state <= S_WAIT_DONE;
                S_WAIT_DONE: if (!tx_busy_i) begin
                    if (last_flag) begin
                        rr_ptr <= grant_id_o;
                        grant_o <= '0;
                        state <= S_AFTER;
                    end else begin
                        state <= S_SEND;
                    end
                end
                S_GAP: begin
                    gcnt <= gap_done ? '0 : gcnt + 1'b1;
                    state <= gap_done ? S_IDLE : S_GAP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
